// File: rtl/fetch_queue_top.sv
// Decoupled fetch stage: sequential PC generation, 1-cycle-latency imem requests,
// and a DEPTH-entry FIFO of {instr, pc, pc+4} feeding decode, with redirect flush.
module fetch_queue_top #(
    parameter int unsigned            DATA_WIDTH = 32,
    parameter int unsigned            DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          redirect_valid,
    input  logic [DATA_WIDTH-1:0]         redirect_pc,
    output logic                          imem_req,
    output logic [DATA_WIDTH-1:0]         imem_addr,
    input  logic [DATA_WIDTH-1:0]         imem_rdata,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DATA_WIDTH-1:0]         out_Instr,
    output logic [DATA_WIDTH-1:0]         out_PC,
    output logic [DATA_WIDTH-1:0]         out_PCPlus4,
    output logic [$clog2(DEPTH+1)-1:0]    count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic                  inflight_q, inflight_d;
    logic [DATA_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    logic [DATA_WIDTH-1:0] instr_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] pc_mem_q    [DEPTH];
    logic [DATA_WIDTH-1:0] pcp4_mem_q  [DEPTH];

    logic [CW:0] occupancy;
    logic        push;
    logic        pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    // Credit counts in-flight fetches but not same-cycle pops, so a push always has a free slot.
    assign occupancy = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign imem_req  = rst && !redirect_valid && (occupancy < (CW+1)'(DEPTH));
    assign imem_addr = pc_q;

    assign push = inflight_q && !redirect_valid;
    assign pop  = (count_q != '0) && out_ready && !redirect_valid;

    assign out_valid   = (count_q != '0);
    assign out_Instr   = instr_mem_q[rd_ptr_q];
    assign out_PC      = pc_mem_q[rd_ptr_q];
    assign out_PCPlus4 = pcp4_mem_q[rd_ptr_q];
    assign count       = count_q;

    always_comb begin
        pc_d          = pc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;

        if (redirect_valid) begin
            pc_d     = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (imem_req) begin
                pc_d          = pc_q + DATA_WIDTH'(4);
                inflight_d    = 1'b1;
                inflight_pc_d = pc_q;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            pc_q          <= pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
                pcp4_mem_q[i]  <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_ptr_q] <= imem_rdata;
            pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
            pcp4_mem_q[wr_ptr_q]  <= inflight_pc_q + DATA_WIDTH'(4);
        end
    end

endmodule

// File: tb/tb_fetch_queue_top.sv
// Directed bench for fetch_queue_top: per-cycle vector table plus hand-written
// sequences for asynchronous reset and PC wrap-around.
module tb_fetch_queue_top;

    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_Instr;
    logic [31:0] out_PC;
    logic [31:0] out_PCPlus4;
    logic [2:0]  count;

    int n_total;
    int n_pass;

    fetch_queue_top #(
        .DATA_WIDTH (32),
        .DEPTH      (4),
        .RESET_PC   (32'h0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_Instr      (out_Instr),
        .out_PC         (out_PC),
        .out_PCPlus4    (out_PCPlus4),
        .count          (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous instruction memory: data for the address presented at an edge appears after it.
    initial imem_rdata = '0;
    always @(posedge clk) imem_rdata <= imem_addr ^ KEY;

    typedef struct {
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        ov;
        logic [31:0] pc;
        int          cnt;
    } vec_t;

    vec_t tbl [26];

    function automatic vec_t mk(input logic rv, input logic [31:0] rpc, input logic rdy,
                                input logic req, input logic [31:0] addr, input logic ov,
                                input logic [31:0] pc, input int cnt);
        vec_t v;
        v.rv = rv; v.rpc = rpc; v.rdy = rdy;
        v.req = req; v.addr = addr; v.ov = ov; v.pc = pc; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, " out_PC"}, out_PC, pc);
        chk({tag, " out_PCPlus4"}, out_PCPlus4, pc + 32'd4);
        chk({tag, " out_Instr"}, out_Instr, pc ^ KEY);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, " imem_req"}, 32'(imem_req), 32'd0);
        chk({tag, " count"}, 32'(count), 32'd0);
        chk({tag, " out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, " out_PC"}, out_PC, 32'd0);
        chk({tag, " out_PCPlus4"}, out_PCPlus4, 32'd0);
        chk({tag, " out_Instr"}, out_Instr, 32'd0);
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;

        // rv, rpc, rdy | req, addr, ov, head pc, count  (state before the next rising edge)
        tbl[0]  = mk(0, 32'h0,   1, 1, 32'd0,   0, 32'd0,   0);
        tbl[1]  = mk(0, 32'h0,   1, 1, 32'd4,   0, 32'd0,   0);
        tbl[2]  = mk(0, 32'h0,   1, 1, 32'd8,   1, 32'd0,   1);
        tbl[3]  = mk(0, 32'h0,   1, 1, 32'd12,  1, 32'd4,   1);
        tbl[4]  = mk(0, 32'h0,   0, 1, 32'd16,  1, 32'd8,   1);
        tbl[5]  = mk(0, 32'h0,   0, 1, 32'd20,  1, 32'd8,   2);
        tbl[6]  = mk(0, 32'h0,   0, 0, 32'd24,  1, 32'd8,   3);
        tbl[7]  = mk(0, 32'h0,   0, 0, 32'd24,  1, 32'd8,   4);
        tbl[8]  = mk(0, 32'h0,   0, 0, 32'd24,  1, 32'd8,   4);
        tbl[9]  = mk(0, 32'h0,   1, 0, 32'd24,  1, 32'd8,   4);
        tbl[10] = mk(0, 32'h0,   1, 1, 32'd24,  1, 32'd12,  3);
        tbl[11] = mk(0, 32'h0,   1, 1, 32'd28,  1, 32'd16,  2);
        tbl[12] = mk(0, 32'h0,   1, 1, 32'd32,  1, 32'd20,  2);
        tbl[13] = mk(0, 32'h0,   0, 1, 32'd36,  1, 32'd24,  2);
        tbl[14] = mk(1, 32'h100, 0, 0, 32'd40,  1, 32'd24,  3);
        tbl[15] = mk(0, 32'h0,   1, 1, 32'h100, 0, 32'h0,   0);
        tbl[16] = mk(0, 32'h0,   1, 1, 32'h104, 0, 32'h0,   0);
        tbl[17] = mk(0, 32'h0,   1, 1, 32'h108, 1, 32'h100, 1);
        tbl[18] = mk(1, 32'h203, 1, 0, 32'h10C, 1, 32'h104, 1);
        tbl[19] = mk(0, 32'h0,   1, 1, 32'h200, 0, 32'h0,   0);
        tbl[20] = mk(0, 32'h0,   1, 1, 32'h204, 0, 32'h0,   0);
        tbl[21] = mk(1, 32'h300, 1, 0, 32'h208, 1, 32'h200, 1);
        tbl[22] = mk(1, 32'h404, 1, 0, 32'h300, 0, 32'h0,   0);
        tbl[23] = mk(0, 32'h0,   1, 1, 32'h404, 0, 32'h0,   0);
        tbl[24] = mk(0, 32'h0,   1, 1, 32'h408, 0, 32'h0,   0);
        tbl[25] = mk(0, 32'h0,   1, 1, 32'h40C, 1, 32'h404, 1);

        rst            = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk_reset_state("reset");
        chk("reset imem_addr", imem_addr, 32'd0);

        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 26; i++) begin
            redirect_valid = tbl[i].rv;
            redirect_pc    = tbl[i].rpc;
            out_ready      = tbl[i].rdy;
            #1;
            chk($sformatf("row%0d imem_req", i), 32'(imem_req), 32'(tbl[i].req));
            chk($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].addr);
            chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(tbl[i].ov));
            chk($sformatf("row%0d count", i), 32'(count), 32'(tbl[i].cnt));
            if (tbl[i].ov) chk_head($sformatf("row%0d", i), tbl[i].pc);
            @(negedge clk);
        end

        // Asynchronous reset asserted between edges while streaming.
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_state("async_rst");
        chk("async_rst imem_addr", imem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("restart imem_req", 32'(imem_req), 32'd1);
        chk("restart imem_addr", imem_addr, 32'd0);
        chk("restart count", 32'(count), 32'd0);
        @(negedge clk);
        #1;
        chk("restart imem_addr2", imem_addr, 32'd4);
        chk("restart out_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk_head("restart", 32'd0);

        // PC wrap-around at the top of the address space.
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFE;
        #1;
        chk("wrap redirect imem_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        #1;
        chk("wrap imem_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap out_valid0", 32'(out_valid), 32'd0);
        @(negedge clk);
        #1;
        chk("wrap imem_addr1", imem_addr, 32'h0000_0000);
        chk("wrap imem_req1", 32'(imem_req), 32'd1);
        @(negedge clk);
        #1;
        chk_head("wrap e0", 32'hFFFF_FFFC);
        chk("wrap e0 pcplus4 zero", out_PCPlus4, 32'h0);
        @(negedge clk);
        #1;
        chk_head("wrap e1", 32'h0);
        chk("wrap count", 32'(count), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not complete, got %0d/%0d", n_pass, n_total);
        $fatal(1);
    end

endmodule
